// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 sensor emulator: FSM state encoding and
// the RGB565 colour-bar palette.
package ov7670_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBACK  = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_VFRONT = 3'd4;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = BAR_WHITE;
      3'd1:    bar_rgb = BAR_YELLOW;
      3'd2:    bar_rgb = BAR_CYAN;
      3'd3:    bar_rgb = BAR_GREEN;
      3'd4:    bar_rgb = BAR_MAGENTA;
      3'd5:    bar_rgb = BAR_RED;
      3'd6:    bar_rgb = BAR_BLUE;
      default: bar_rgb = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_sensor_tx_if.sv
// Camera-side bus of the OV7670 emulator: frame request in, sync/data out.
interface ov7670_sensor_tx_if;
  logic       enable;
  logic       vsync;
  logic       href;
  logic [7:0] d;
  logic       frame_done;

  modport master (input enable, output vsync, output href, output d, output frame_done);
  modport slave  (output enable, input vsync, input href, input d, input frame_done);
endinterface

// File: rtl/ov7670_pattern_gen.sv
// Maps (column, line) to an RGB565 pixel. Colour bars when OV7670_TX_COLORBAR_EN
// is defined, otherwise the {line, column} counting pattern.
module ov7670_pattern_gen
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] i_col,
  input  logic [7:0]  i_row,
  output logic [15:0] o_pix
);

`ifdef OV7670_TX_COLORBAR_EN
  localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

  logic [15:0] w_bar;
  logic [2:0]  w_idx;
  logic        w_unused;

  assign w_bar    = i_col / BAR_W;
  // Columns past the eighth bar (H_ACTIVE not a multiple of 8) stay on the last bar.
  assign w_idx    = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
  assign o_pix    = bar_rgb(w_idx);
  assign w_unused = ^i_row;
`else
  logic w_unused;

  assign o_pix    = {i_row, i_col[7:0]};
  assign w_unused = ^i_col[15:8];
`endif

endmodule

// File: rtl/ov7670_sensor_tx.sv
// OV7670-style frame generator: vsync/href/d timing with all outputs registered.
// Pixel content selectable via OV7670_TX_COLORBAR_EN (see ov7670_pattern_gen).
module ov7670_sensor_tx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input logic                 pclk,
  input logic                 reset,
  ov7670_sensor_tx_if.master  bus
);

  localparam int L    = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(L);
  localparam int VMAX = (V_ACTIVE > V_BACK) ?
                        ((V_ACTIVE > VSYNC_LINES) ? ((V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT)
                                                  : ((VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT))
                      : ((V_BACK > VSYNC_LINES) ? ((V_BACK > V_FRONT) ? V_BACK : V_FRONT)
                                                : ((VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT));
  localparam int LW   = ($clog2(VMAX + 1) > 8) ? $clog2(VMAX + 1) : 8;

  localparam logic [HW-1:0] H_LAST    = HW'(L - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VB_LAST   = LW'(V_BACK - 1);
  localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VF_LAST   = LW'(V_FRONT - 1);

  state_t        r_state, w_state_next;
  logic [HW-1:0] r_h, w_h_next;
  logic [LW-1:0] r_l, w_l_next, w_l_last;
  logic          r_vsync, r_href, r_frame_done;
  logic [7:0]    r_d;
  logic          w_href_next;
  logic [15:0]   w_pix;
  logic [15:0]   w_col;

  always_comb begin
    w_state_next = r_state;
    w_h_next     = r_h;
    w_l_next     = r_l;
    case (r_state)
      ST_VSYNC:  w_l_last = VS_LAST;
      ST_VBACK:  w_l_last = VB_LAST;
      ST_ACTIVE: w_l_last = VA_LAST;
      default:   w_l_last = VF_LAST;
    endcase

    if (r_state == ST_IDLE) begin
      if (bus.enable) begin
        w_state_next = ST_VSYNC;
        w_h_next     = '0;
        w_l_next     = '0;
      end
    end else if (r_h != H_LAST) begin
      w_h_next = r_h + 1'b1;
    end else begin
      w_h_next = '0;
      if (r_l != w_l_last) begin
        w_l_next = r_l + 1'b1;
      end else begin
        w_l_next = '0;
        case (r_state)
          ST_VSYNC:  w_state_next = ST_VBACK;
          ST_VBACK:  w_state_next = ST_ACTIVE;
          ST_ACTIVE: w_state_next = ST_VFRONT;
          // enable is only honoured here and in IDLE; back-to-back frames have no gap.
          ST_VFRONT: w_state_next = bus.enable ? ST_VSYNC : ST_IDLE;
          default:   w_state_next = ST_IDLE;
        endcase
      end
    end
  end

  assign w_href_next = (w_state_next == ST_ACTIVE) && (w_h_next < H_ACT_END);
  assign w_col       = 16'(w_h_next >> 1);

  ov7670_pattern_gen #(.H_ACTIVE(H_ACTIVE)) u_pattern (
    .i_col (w_col),
    .i_row (w_l_next[7:0]),
    .o_pix (w_pix)
  );

  always_ff @(posedge pclk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_h          <= '0;
      r_l          <= '0;
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_d          <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_h          <= w_h_next;
      r_l          <= w_l_next;
      r_vsync      <= (w_state_next == ST_VSYNC);
      r_href       <= w_href_next;
      r_d          <= w_href_next ? (w_h_next[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;
      r_frame_done <= (w_state_next == ST_VFRONT) && (w_h_next == H_LAST) && (w_l_next == VF_LAST);
    end
  end

  assign bus.vsync      = r_vsync;
  assign bus.href       = r_href;
  assign bus.d          = r_d;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_ov7670_sensor_tx.sv
// Directed bench for ov7670_sensor_tx with a small frame (L=18, 90-cycle frame).
// Expected pixel bytes follow OV7670_TX_COLORBAR_EN when the bench is built with it.
module tb_ov7670_sensor_tx;

  localparam int HA = 8, HB = 2, VA = 2, VS = 1, VB = 1, VF = 1;

  logic pclk  = 1'b0;
  logic reset = 1'b1;

  ov7670_sensor_tx_if bus ();

  ov7670_sensor_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int         cyc;
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       fd;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   fd_count = 0;
  int   dz_bad   = 0;
  int   vi       = 0;

  // Cycle k is the period after the k-th rising edge since enable was first sampled.
  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
    if (bus.frame_done === 1'b1) fd_count++;
    if (bus.href !== 1'b1 && bus.d !== 8'h00) dz_bad++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end else begin
      $display("check %s cyc=%0d got=%0h ok", name, cyc, got);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int r, input int j);
    logic [15:0] pix;
`ifdef OV7670_TX_COLORBAR_EN
    case (j / 2)
      0: pix = 16'hFFFF;
      1: pix = 16'hFFE0;
      2: pix = 16'h07FF;
      3: pix = 16'h07E0;
      4: pix = 16'hF81F;
      5: pix = 16'hF800;
      6: pix = 16'h001F;
      default: pix = 16'h0000;
    endcase
`else
    pix = {8'(r), 8'(j / 2)};
`endif
    return (j % 2 == 0) ? pix[15:8] : pix[7:0];
  endfunction

  function automatic void add(input int c, input logic v, input logic h,
                              input logic [7:0] dd, input logic f);
    vec_t e;
    e.cyc = c; e.vs = v; e.hr = h; e.d = dd; e.fd = f;
    vecs.push_back(e);
  endfunction

  initial begin
    // Two frames back to back, enable dropped at cycle 100 during the second.
    add(1, 1, 0, 8'h00, 0);
    add(18, 1, 0, 8'h00, 0);
    add(19, 0, 0, 8'h00, 0);
    add(36, 0, 0, 8'h00, 0);
    for (int j = 0; j < 16; j++) add(37 + j, 0, 1, exp_byte(0, j), 0);
    add(53, 0, 0, 8'h00, 0);
    add(54, 0, 0, 8'h00, 0);
    for (int j = 0; j < 16; j++) add(55 + j, 0, 1, exp_byte(1, j), 0);
    add(71, 0, 0, 8'h00, 0);
    add(72, 0, 0, 8'h00, 0);
    add(73, 0, 0, 8'h00, 0);
    add(89, 0, 0, 8'h00, 0);
    add(90, 0, 0, 8'h00, 1);
    add(91, 1, 0, 8'h00, 0);
    add(108, 1, 0, 8'h00, 0);
    add(109, 0, 0, 8'h00, 0);
    add(127, 0, 1, exp_byte(0, 0), 0);
    add(180, 0, 0, 8'h00, 1);
    add(181, 0, 0, 8'h00, 0);
    add(185, 0, 0, 8'h00, 0);

    bus.enable = 1'b1;
    reset      = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    chk("reset_vsync", bus.vsync, 0);
    chk("reset_href", bus.href, 0);
    chk("reset_d", bus.d, 0);
    chk("reset_frame_done", bus.frame_done, 0);

    reset    = 1'b0;
    cyc      = 0;
    fd_count = 0;
    dz_bad   = 0;
    for (int k = 0; k < 185; k++) begin
      tick();
      if (cyc == 100) bus.enable = 1'b0;
      while (vi < vecs.size() && vecs[vi].cyc == cyc) begin
        chk($sformatf("vec%0d_vsync", vi), bus.vsync, vecs[vi].vs);
        chk($sformatf("vec%0d_href", vi), bus.href, vecs[vi].hr);
        chk($sformatf("vec%0d_d", vi), bus.d, vecs[vi].d);
        chk($sformatf("vec%0d_frame_done", vi), bus.frame_done, vecs[vi].fd);
        vi++;
      end
    end
    chk("vectors_applied", vi, vecs.size());
    chk("frame_done_pulses", fd_count, 2);
    chk("d_zero_when_href_low", dz_bad, 0);

    // Mid-href reset with enable still high, then a restart from VSYNC.
    reset = 1'b1;
    tick();
    reset      = 1'b0;
    bus.enable = 1'b1;
    cyc        = 0;
    fd_count   = 0;
    run_to(40);
    chk("pre_reset_href", bus.href, 1);
    chk("pre_reset_d", bus.d, exp_byte(0, 3));
    reset = 1'b1;
    tick();
    chk("midreset_vsync", bus.vsync, 0);
    chk("midreset_href", bus.href, 0);
    chk("midreset_d", bus.d, 0);
    chk("midreset_frame_done", bus.frame_done, 0);
    chk("midreset_no_done", fd_count, 0);
    reset = 1'b0;
    tick();
    chk("restart_vsync", bus.vsync, 1);
    bus.enable = 1'b0;
    run_to(59);
    chk("restart_vsync_last", bus.vsync, 1);
    tick();
    chk("restart_vsync_fall", bus.vsync, 0);
    run_to(78);
    chk("restart_href", bus.href, 1);
    run_to(130);
    chk("restart_done_early", bus.frame_done, 0);
    tick();
    chk("restart_done", bus.frame_done, 1);
    tick();
    chk("restart_idle_vsync", bus.vsync, 0);
    chk("restart_done_count", fd_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ov7670_sensor_tx.md
OV7670_SENSOR_TX -- requirements
Module: ov7670_sensor_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640, active pixels per line (even, >=8).
REQ-002 Parameter H_BLANK, default 144, pclk cycles with href low after each line's active bytes.
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 Parameter VSYNC_LINES, default 3, line periods with vsync high.
REQ-005 Parameter V_BACK, default 17, blank line periods between vsync fall and first active line.
REQ-006 Parameter V_FRONT, default 10, blank line periods after last active line.
REQ-007 pclk  input  1  pixel clock, sole clock; all logic rising-edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 enable  input  1  frame generation request, sampled only in IDLE.
REQ-010 vsync  output  1  vertical sync, active high.
REQ-011 href  output  1  horizontal reference, high during active bytes.
REQ-012 d  output  8  pixel byte, RGB565, high byte first.
REQ-013 frame_done  output  1  one-cycle pulse on the last cycle of each frame.

Function
REQ-014 All outputs SHALL be registered; line period L = 2*H_ACTIVE + H_BLANK cycles.
REQ-015 States SHALL be IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
REQ-016 IDLE with enable=1 at edge N SHALL give vsync=1 from cycle N+1 (state VSYNC).
REQ-017 VSYNC SHALL last VSYNC_LINES*L cycles, then VBACK for V_BACK*L cycles, then ACTIVE.
REQ-018 ACTIVE SHALL contain V_ACTIVE lines: href high 2*H_ACTIVE cycles, then low H_BLANK cycles.
REQ-019 VFRONT SHALL last V_FRONT*L cycles; frame_done=1 on its final cycle only.
REQ-020 After VFRONT: enable=1 SHALL go directly to VSYNC (no idle cycle); enable=0 SHALL go to IDLE.
REQ-021 enable changes outside IDLE/VFRONT-end SHALL be ignored; frames always complete.
REQ-022 href SHALL be 0 in IDLE, VSYNC, VBACK, VFRONT; vsync SHALL be 0 outside VSYNC.
REQ-023 d SHALL be 0x00 whenever href=0.
REQ-024 Pixel at column c, line r: first byte = pix[15:8], second = pix[7:0].
REQ-025 Default pattern: pix = {r[7:0], c[7:0]} (counters wrap modulo 256).
REQ-026 Column and line counters SHALL reset to 0 at start of each line/frame respectively.

Reset
REQ-027 reset=1 SHALL, on the next edge, force state IDLE, counters 0, vsync=href=frame_done=0, d=0x00.
REQ-028 Reset mid-frame SHALL abort the frame without frame_done; next frame restarts from VSYNC.
REQ-029 reset SHALL take priority over enable on the same edge.

Configuration
REQ-030 Macro OV7670_TX_COLORBAR_EN defined: pix SHALL be colour bars, bar index = c / (H_ACTIVE/8), values FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
REQ-031 Macro undefined: pix SHALL follow REQ-025; no bar logic synthesised.
REQ-032 Timing (vsync, href, frame_done) SHALL be identical in both builds.

Structure
REQ-033 Package ov7670_pkg SHALL hold the state encoding and the eight RGB565 bar constants.
REQ-034 Sub-module ov7670_pattern_gen SHALL map (c, r) to pix; sole location of the macro.

Verification (H_ACTIVE=8, H_BLANK=2, V_ACTIVE=2, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; L=18)
REQ-035 Reset then enable=1 at edge 0 -> vsync=1 cycles 1-18, href rises cycle 37, frame_done at cycle 90 only.
REQ-036 Default build, line 1 -> d sequence 01,00,01,01,...,01,07 over 16 href cycles, then 00,00.
REQ-037 COLORBAR build, line 0 -> bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
REQ-038 enable held high -> second frame vsync=1 at cycle 91, no gap; enable dropped mid-frame -> frame completes, IDLE after frame_done.
REQ-039 reset asserted at cycle 40 (mid-href) -> cycle 41 all outputs 0, no frame_done; enable then restarts from VSYNC.
